periph_timer: RTL and testbench

PERIPH_TIMER -- requirements
Module: periph_timer

---
 rtl/periph_timer_pkg.sv | 36 +++
 rtl/timer_core.sv | 65 ++++++
 rtl/periph_timer.sv | 77 +++++++
 tb/tb_periph_timer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_timer_pkg.sv
// Shared address map, TCON bit positions and decode helper for the timer peripheral.
// Used by periph_timer and by the data-bus address decoder.
package periph_timer_pkg;

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_LED,
    REG_SYSTICK
  } reg_sel_e;

  // Word decode: byte-lane bits [1:0] never take part in the match.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr[31:2] == ADDR_TH[31:2])      sel = REG_TH;
    if (addr[31:2] == ADDR_TL[31:2])      sel = REG_TL;
    if (addr[31:2] == ADDR_TCON[31:2])    sel = REG_TCON;
    if (addr[31:2] == ADDR_LED[31:2])     sel = REG_LED;
    if (addr[31:2] == ADDR_SYSTICK[31:2]) sel = REG_SYSTICK;
    return sel;
  endfunction

endpackage

// File: rtl/timer_core.sv
// TH/TL reload counter with TCON control/status and registered interrupt level.
// Writes commit on the edge; no backpressure, strobes are always accepted.
module timer_core
  import periph_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        th_wr,
  input  logic        tl_wr,
  input  logic        tcon_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        irq_q, irq_d;
  logic        ovf;
  logic        st_set;

  assign ovf    = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
  assign st_set = ovf && tcon_q[TCON_IE];

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (th_wr) th_d = wr_data;

    if (tl_wr)                tl_d = wr_data;
    else if (ovf)             tl_d = th_q;
    else if (tcon_q[TCON_EN]) tl_d = tl_q + 32'd1;

    // Hardware set of the status bit beats a software clear in the same cycle.
    if (tcon_wr) tcon_d = wr_data[2:0];
    if (st_set)  tcon_d[TCON_ST] = 1'b1;

    irq_d = tcon_d[TCON_ST] & tcon_d[TCON_IE];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      irq_q  <= irq_d;
    end
  end

  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;
  assign irq  = irq_q;

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped timer/LED/SYSTICK peripheral; reads are combinational, writes commit on the edge.
// No backpressure: every bus strobe completes in its own cycle.
module periph_timer
  import periph_timer_pkg::*;
(
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRd,
  input  logic        iWr,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  output logic        oAccessable,
  output logic        oIrq,
  output logic [7:0]  oLed,
  output logic [31:0] oSysTick
);

  reg_sel_e    sel;
  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic [7:0]  led_q, led_d;
  logic [31:0] systick_q, systick_d;
  logic        unused_addr_lanes;

  assign sel               = decode_addr(iAddr);
  assign oAccessable       = (sel != REG_NONE);
  assign unused_addr_lanes = ^iAddr[1:0];

  timer_core u_timer_core (
    .clk     (iClk),
    .rst     (iRst),
    .th_wr   (iWr && (sel == REG_TH)),
    .tl_wr   (iWr && (sel == REG_TL)),
    .tcon_wr (iWr && (sel == REG_TCON)),
    .wr_data (iWrData),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (oIrq)
  );

  always_comb begin
    led_d     = led_q;
    systick_d = systick_q + 32'd1;
    if (iWr && (sel == REG_LED)) led_d = iWrData[7:0];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      led_q     <= '0;
      systick_q <= '0;
    end else begin
      led_q     <= led_d;
      systick_q <= systick_d;
    end
  end

  // Reads show the current register value, so a same-cycle write is not yet visible.
  always_comb begin
    oRdData = 32'h0;
    if (iRd) begin
      case (sel)
        REG_TH:      oRdData = th;
        REG_TL:      oRdData = tl;
        REG_TCON:    oRdData = {29'h0, tcon};
        REG_LED:     oRdData = {24'h0, led_q};
        REG_SYSTICK: oRdData = systick_q;
        default:     oRdData = 32'h0;
      endcase
    end
  end

  assign oLed     = led_q;
  assign oSysTick = systick_q;

endmodule

// File: tb/tb_periph_timer.sv
// Scoreboard bench for periph_timer: reads push expected data, a negedge monitor pops and compares.
module tb_periph_timer;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_HOLE = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iRd = 1'b0;
  logic        iWr = 1'b0;
  logic [31:0] iAddr = 32'h0;
  logic [31:0] iWrData = 32'h0;
  logic [31:0] oRdData;
  logic        oAccessable;
  logic        oIrq;
  logic [7:0]  oLed;
  logic [31:0] oSysTick;

  periph_timer dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iRd         (iRd),
    .iWr         (iWr),
    .iAddr       (iAddr),
    .iWrData     (iWrData),
    .oRdData     (oRdData),
    .oAccessable (oAccessable),
    .oIrq        (oIrq),
    .oLed        (oLed),
    .oSysTick    (oSysTick)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [31:0] q_exp[$];
  string       q_name[$];

  // Reference state: the register file as the programmer sees it.
  logic [31:0] m_th = 0, m_tl = 0, m_tick = 0;
  logic [7:0]  m_led = 0;
  logic        m_en = 0, m_ie = 0, m_st = 0;

  function automatic bit is_reg(input logic [31:0] a, input logic [31:0] r);
    return (a >> 2) == (r >> 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return is_reg(a, A_TH) || is_reg(a, A_TL) || is_reg(a, A_TCON) ||
           is_reg(a, A_LED) || is_reg(a, A_TICK);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (is_reg(a, A_TH))   return m_th;
    if (is_reg(a, A_TL))   return m_tl;
    if (is_reg(a, A_TCON)) return {29'h0, m_st, m_ie, m_en};
    if (is_reg(a, A_LED))  return {24'h0, m_led};
    if (is_reg(a, A_TICK)) return m_tick;
    return 32'h0;
  endfunction

  always @(posedge iClk) begin
    if (iRst) begin
      m_th <= 0; m_tl <= 0; m_tick <= 0; m_led <= 0;
      m_en <= 0; m_ie <= 0; m_st <= 0;
    end else begin
      m_tick <= m_tick + 1;
      if (iWr && is_reg(iAddr, A_TH)) m_th <= iWrData;
      if (iWr && is_reg(iAddr, A_LED)) m_led <= iWrData[7:0];
      if (iWr && is_reg(iAddr, A_TL)) m_tl <= iWrData;
      else if (m_en) m_tl <= (m_tl == 32'hFFFF_FFFF) ? m_th : m_tl + 1;
      if (iWr && is_reg(iAddr, A_TCON)) begin
        m_en <= iWrData[0];
        m_ie <= iWrData[1];
      end
      m_st <= (m_en && m_ie && m_tl == 32'hFFFF_FFFF) ? 1'b1 :
              (iWr && is_reg(iAddr, A_TCON)) ? iWrData[2] : m_st;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge iClk) begin
    if (mon_en && !iRst) begin
      check("irq", {31'h0, oIrq}, {31'h0, m_st & m_ie});
      check("led", {24'h0, oLed}, {24'h0, m_led});
      check("systick", oSysTick, m_tick);
      check("accessable", {31'h0, oAccessable}, {31'h0, m_hit(iAddr)});
      if (iRd) begin
        if (q_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_underflow: got read with no expected entry at %0t", $time);
        end else begin
          logic [31:0] e;
          string n;
          e = q_exp.pop_front();
          n = q_name.pop_front();
          check(n, oRdData, e);
        end
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    iRd = rd; iWr = wr; iAddr = a; iWrData = d;
    @(posedge iClk);
    #1;
    iRd = 1'b0; iWr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [31:0] exp, input string nm);
    q_exp.push_back(exp);
    q_name.push_back(nm);
    drive(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic acc_chk(input logic [31:0] a, input logic exp, input string nm);
    iAddr = a;
    #2;
    check(nm, {31'h0, oAccessable}, {31'h0, exp});
    drive(1'b0, 1'b0, a, 32'h0);
  endtask

  initial begin
    logic [31:0] addrs[8];
    addrs[0] = A_TH; addrs[1] = A_TL; addrs[2] = A_TCON; addrs[3] = A_LED;
    addrs[4] = A_TICK; addrs[5] = A_HOLE; addrs[6] = 32'h0; addrs[7] = A_TL;

    iRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b0;
    mon_en = 1'b1;

    // Reset state and address map
    rd_exp(A_TICK, 32'h0, "rst_systick");
    rd_exp(A_TH, 32'h0, "rst_th");
    rd_exp(A_TL, 32'h0, "rst_tl");
    rd_exp(A_TCON, 32'h0, "rst_tcon");
    rd_exp(A_LED, 32'h0, "rst_led");
    check("rst_irq", {31'h0, oIrq}, 32'h0);
    acc_chk(A_HOLE, 1'b0, "acc_hole");
    acc_chk(32'h0, 1'b0, "acc_zero");
    acc_chk(A_TICK | 32'h3, 1'b1, "acc_lanes");

    // Overflow reload with interrupt
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    rd_exp(A_TL, 32'hFFFF_FFFE, "tl_pre");
    rd_exp(A_TL, 32'hFFFF_FFFF, "tl_max");
    rd_exp(A_TL, 32'hFFFF_FFF0, "tl_reload");
    check("irq_set", {31'h0, oIrq}, 32'h1);
    rd_exp(A_TCON, 32'h7, "tcon_ovf");

    // Software clear, then clear colliding with overflow
    wr(A_TCON, 32'h3);
    check("irq_clr", {31'h0, oIrq}, 32'h0);
    rd_exp(A_TCON, 32'h3, "tcon_clr");
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    rd_exp(A_TCON, 32'h7, "tcon_hw_wins");
    check("irq_hw_wins", {31'h0, oIrq}, 32'h1);

    // TL write colliding with overflow, interrupts disabled
    wr(A_TCON, 32'h1);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TL, 32'h5);
    rd_exp(A_TL, 32'h5, "tl_sw_wins");
    rd_exp(A_TCON, 32'h1, "tcon_no_st");

    // LED width, read-only SYSTICK, read-during-write
    wr(A_LED, 32'h1A5);
    check("led_out", {24'h0, oLed}, 32'hA5);
    rd_exp(A_LED, 32'hA5, "led_rd");
    wr(A_TICK, 32'h0);
    rd_exp(A_TH, 32'hFFFF_FFF0, "th_before_rw");
    q_exp.push_back(32'hFFFF_FFF0);
    q_name.push_back("rw_prewrite");
    drive(1'b1, 1'b1, A_TH, 32'h1234);
    rd_exp(A_TH, 32'h1234, "rw_after");

    // Reset with counting timer and pending interrupt
    wr(A_TCON, 32'h3);
    wr(A_TL, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check("irq_pre_rst", {31'h0, oIrq}, 32'h1);
    iRst = 1'b1;
    drive(1'b0, 1'b1, A_LED, 32'hFF);
    iRst = 1'b0;
    check("irq_post_rst", {31'h0, oIrq}, 32'h0);
    rd_exp(A_TICK, 32'h0, "post_rst_systick");
    rd_exp(A_TL, 32'h0, "post_rst_tl");
    rd_exp(A_TH, 32'h0, "post_rst_th");
    rd_exp(A_TCON, 32'h0, "post_rst_tcon");
    rd_exp(A_LED, 32'h0, "post_rst_led");

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, d;
      logic rd, w;
      int k;
      k = $urandom_range(0, 7);
      a = (k == 6) ? $urandom : addrs[k] | ($urandom & 32'h3);
      rd = $urandom_range(0, 1) == 1;
      w = $urandom_range(0, 2) == 0;
      d = $urandom;
      if (is_reg(a, A_TL) && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      if (is_reg(a, A_TH) && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
      if ($urandom_range(0, 299) == 0) begin
        iRst = 1'b1;
        drive(1'b0, w, a, d);
        iRst = 1'b0;
      end else begin
        if (rd) begin
          q_exp.push_back(m_read(a));
          q_name.push_back("rand_rd");
        end
        drive(rd, w, a, d);
      end
    end

    repeat (2) @(posedge iClk);
    #1;
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL rd_drain: got %0d pending expected 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
